// File: rtl/inst_fetch.sv
// Purpose     : PC holder and single-outstanding-request fetcher feeding a decode FIFO.
// Latency     : first request 1 cycle after reset/IDLE; a returned word shows on inst_valid 1 cycle after ready.
// Backpressure: decode stalls via inst_ready; issue stops while the FIFO cannot absorb the next word.
//
// Ports:
//   clk, rst                 clock and asynchronous active-low reset
//   redirect_en, redirect_pc branch redirect: flush buffered words, load PC (word aligned)
//   read_en, addr_read       registered cache read request, held until ready
//   ready, data_in           cache response strobe and data, valid in the same cycle
//   inst_valid/pc/data       FIFO head towards decode
//   inst_ready               decode pops the head when inst_valid && inst_ready

// Purpose     : circular FIFO with wrap-bit pointers and synchronous flush.
// Latency     : a push is visible at out_vld/out_dat one cycle later; head read straight from storage.
// Backpressure: pop while empty is ignored; push while full only succeeds alongside a pop.
module inst_fetch_fifo #(
    parameter int W  = 64,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_vld,
    input  logic [W-1:0]  in_dat,
    output logic          out_vld,
    output logic [W-1:0]  out_dat,
    input  logic          out_rdy,
    output logic [AW:0]   count
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         full;
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = out_rdy && !empty;
    assign do_push = in_vld && (!full || do_pop);

    assign out_vld = !empty;
    assign out_dat = mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= in_dat;
    end
endmodule

module inst_fetch #(
    parameter int                    ADDR_WIDTH       = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC         = 32'hbfc00000,
    parameter int                    FIFO_DEPTH_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  read_en,
    output logic [ADDR_WIDTH-1:0] addr_read,
    input  logic                  ready,
    input  logic [31:0]           data_in,
    output logic                  inst_valid,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic [31:0]           inst_data,
    input  logic                  inst_ready
);
    localparam int FDW = FIFO_DEPTH_WIDTH;
    localparam logic [FDW+1:0] DEPTH = {1'b0, 1'b1, {FDW{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] WORD = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [31:0]           dat;
    } inst_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] redir_al;
    logic                  push_vld;
    logic                  pop_vld;
    logic [FDW:0]          fifo_count;
    logic [FDW+1:0]        count_next;
    logic                  space;
    inst_t                 push_dat;
    inst_t                 head_dat;

    assign redir_al = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    // A response is only kept in REQ without a concurrent redirect; DROP responses vanish.
    assign push_vld = (state == REQ) && ready && !redirect_en;
    assign pop_vld  = inst_valid && inst_ready;

    // Issue decision looks at occupancy after this cycle's push/pop so a push can never overflow.
    assign count_next = {1'b0, fifo_count}
                      + {{(FDW+1){1'b0}}, push_vld}
                      - {{(FDW+1){1'b0}}, pop_vld};
    assign space = (count_next < DEPTH);

    assign push_dat.pc  = addr_read;
    assign push_dat.dat = data_in;

    inst_fetch_fifo #(
        .W  ($bits(inst_t)),
        .AW (FDW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_en),
        .in_vld  (push_vld),
        .in_dat  (push_dat),
        .out_vld (inst_valid),
        .out_dat (head_dat),
        .out_rdy (pop_vld),
        .count   (fifo_count)
    );

    assign inst_pc   = head_dat.pc;
    assign inst_data = head_dat.dat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            read_en   <= 1'b0;
            addr_read <= '0;
            pc        <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_en) begin
                        pc <= redir_al;
                    end else if (space) begin
                        read_en   <= 1'b1;
                        addr_read <= pc;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (ready && !redirect_en) begin
                        pc <= addr_read + WORD;
                        if (space) begin
                            addr_read <= addr_read + WORD;
                        end else begin
                            read_en <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (ready) begin
                        pc      <= redir_al;
                        read_en <= 1'b0;
                        state   <= IDLE;
                    end else if (redirect_en) begin
                        // Request stays on the bus; its eventual response is stale.
                        pc    <= redir_al;
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (redirect_en) pc <= redir_al;
                    if (ready) begin
                        read_en <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    read_en <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ready = 1'b0;
    logic [31:0] data_in = '0;
    logic        inst_ready = 1'b0;
    logic        read_en;
    logic [31:0] addr_read;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    inst_fetch #(
        .ADDR_WIDTH       (32),
        .RESET_PC         (32'hbfc00000),
        .FIFO_DEPTH_WIDTH (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .read_en     (read_en),
        .addr_read   (addr_read),
        .ready       (ready),
        .data_in     (data_in),
        .inst_valid  (inst_valid),
        .inst_pc     (inst_pc),
        .inst_data   (inst_data),
        .inst_ready  (inst_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] dat;
    } ent_t;

    int          nerr = 0;
    int          nchk = 0;
    ent_t        mq[$];
    bit          m_out;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    int          lat = 0;
    int          wcnt = 0;
    bit          rand_lat = 1'b0;
    logic [31:0] got[$];
    int          n_rdy = 0;
    int          n_pop = 0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0F1E2D3C;
    endfunction

    function automatic logic [31:0] got_at(input int k);
        if (got.size() > k) return got[k];
        return 32'hdeadbeef;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_pc   = 32'hbfc00000;
        m_addr = 32'h0;
        wcnt   = 0;
    endtask

    // Cache side: answers the single outstanding request after 'lat' wait cycles.
    task automatic drive(input bit redir, input logic [31:0] rpc, input bit ir);
        redirect_en = redir;
        redirect_pc = rpc;
        inst_ready  = ir;
        ready       = m_out && (wcnt >= lat);
        data_in     = ready ? data_of(addr_read) : $urandom;
        if (ready) begin
            got.push_back(addr_read);
            n_rdy++;
        end
        if (ir && mq.size() > 0) n_pop++;
    endtask

    // Reference behaviour: one outstanding fetch, a queue of {pc,data}, redirect kills everything buffered.
    task automatic model_step();
        bit          pop;
        logic [31:0] rpc;
        pop = inst_ready && (mq.size() > 0);
        rpc = {redirect_pc[31:2], 2'b00};
        if (redirect_en) begin
            mq.delete();
            m_pc = rpc;
            if (m_out) begin
                if (ready) begin
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    m_drop = 1'b1;
                end
            end
        end else if (m_out && ready) begin
            if (m_drop) begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end else begin
                if (pop) void'(mq.pop_front());
                mq.push_back('{m_addr, data_in});
                m_pc = m_addr + 32'd4;
                if (mq.size() < DEPTH) m_addr = m_addr + 32'd4;
                else m_out = 1'b0;
            end
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_out && mq.size() < DEPTH) begin
                m_out  = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    task automatic compare();
        check("read_en", 32'(read_en), 32'(m_out));
        check("addr_read", addr_read, m_addr);
        check("inst_valid", 32'(inst_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("inst_pc", inst_pc, mq[0].pc);
            check("inst_data", inst_data, mq[0].dat);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ready) wcnt = 0;
        else if (m_out) wcnt++;
        model_step();
        compare();
        if (ready && rand_lat) lat = $urandom_range(0, 3);
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        redirect_en = 1'b0;
        ready       = 1'b0;
        inst_ready  = 1'b0;
        data_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_read_en", 32'(read_en), 32'd0);
        check("rst_addr_read", addr_read, 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        model_reset();
        got.delete();
        n_rdy = 0;
        n_pop = 0;
        rst   = 1'b1;
    endtask

    initial begin
        // Sequential fetch, cache answers one cycle after each request.
        lat = 1;
        do_reset();
        for (int i = 0; i < 20; i++) begin drive(0, 0, 1); tick(); end
        check("t1_responses", 32'(n_rdy), 32'd9);
        check("t1_pops", 32'(n_pop), 32'd9);
        for (int k = 0; k < 4; k++) check("t1_addr_seq", got_at(k), 32'hbfc00000 + 32'(4 * k));

        // Decode stalled: FIFO fills to 8 then issue stops; one pop re-issues.
        lat = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin drive(0, 0, 0); tick(); end
        check("t2_pushes", 32'(n_rdy), 32'd8);
        check("t2_model_depth", 32'(mq.size()), 32'd8);
        check("t2_idle_read_en", 32'(read_en), 32'd0);
        drive(0, 0, 1); tick();
        check("t2_reissue_en", 32'(read_en), 32'd1);
        check("t2_reissue_addr", addr_read, 32'hbfc00020);

        // Redirect while waiting; stale response three cycles later is discarded.
        lat = 3;
        do_reset();
        drive(0, 0, 1); tick();
        drive(1, 32'h80001003, 1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1); tick();
            check("t3_no_valid", 32'(inst_valid), 32'd0);
        end
        check("t3_drop_done", 32'(read_en), 32'd0);
        drive(0, 0, 1); tick();
        check("t3_new_en", 32'(read_en), 32'd1);
        check("t3_new_addr", addr_read, 32'h80001000);

        // Redirect coinciding with ready: nothing pushed, FIFO empty next cycle.
        lat = 1;
        do_reset();
        for (int i = 0; i < 6; i++) begin drive(0, 0, 0); tick(); end
        check("t4_buffered", 32'(inst_valid), 32'd1);
        drive(1, 32'h12345678, 0); tick();
        check("t4_flushed", 32'(inst_valid), 32'd0);
        check("t4_idle", 32'(read_en), 32'd0);
        drive(0, 0, 0); tick();
        check("t4_new_en", 32'(read_en), 32'd1);
        check("t4_new_addr", addr_read, 32'h12345678);

        // PC wraps modulo 2^32.
        lat = 0;
        do_reset();
        drive(0, 0, 1); tick();
        drive(1, 32'hFFFFFFF8, 1); tick();
        got.delete();
        for (int i = 0; i < 8; i++) begin drive(0, 0, 1); tick(); end
        check("t5_wrap0", got_at(0), 32'hFFFFFFF8);
        check("t5_wrap1", got_at(1), 32'hFFFFFFFC);
        check("t5_wrap2", got_at(2), 32'h00000000);

        // Asynchronous reset mid-request with entries buffered.
        lat = 1;
        do_reset();
        for (int i = 0; i < 50 && !(mq.size() == 3 && m_out); i++) begin drive(0, 0, 0); tick(); end
        check("t6_setup", 32'(mq.size() == 3 && m_out), 32'd1);
        #2;
        rst   = 1'b0;
        ready = 1'b0;
        #1;
        check("t6_async_read_en", 32'(read_en), 32'd0);
        check("t6_async_valid", 32'(inst_valid), 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
        drive(0, 0, 1); tick();
        check("t6_first_en", 32'(read_en), 32'd1);
        check("t6_first_addr", addr_read, 32'hbfc00000);

        // Randomized traffic: latencies, decode stalls, redirects (some near the wrap point).
        do_reset();
        rand_lat = 1'b1;
        lat = $urandom_range(0, 3);
        for (int i = 0; i < 4000; i++) begin
            int          r;
            int          pr;
            bit          redir;
            logic [31:0] rpc;
            pr    = ((i / 500) % 2 == 0) ? 30 : 90;
            r     = $urandom_range(0, 99);
            redir = (r < 4);
            rpc   = (r < 2) ? $urandom : (32'hFFFFFFF0 + 32'($urandom_range(0, 15)));
            drive(redir, rpc, $urandom_range(0, 99) < pr);
            tick();
        end
        rand_lat = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Fetch stage directly upstream of the instruction cache. Holds the PC and issues one word read at a time on the cache read_en/addr_read/ready handshake. Buffers returned words with their PCs in a small FIFO for decode. Handles branch redirects by flushing the FIFO and discarding any in-flight cache response.

Parameters:
ADDR_WIDTH, 32, address/PC width
RESET_PC, 32'hbfc00000, PC after reset
FIFO_DEPTH_WIDTH, 3, log2 of FIFO entries (default 8)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset
redirect_en  input  1  redirect request: flush FIFO and load PC
redirect_pc  input  ADDR_WIDTH  redirect target; bits [1:0] forced to 0
read_en  output  1  cache read request (registered)
addr_read  output  ADDR_WIDTH  cache read address (registered, word aligned)
ready  input  1  cache response strobe; data_in is valid in the same cycle
data_in  input  32  cache data_out
inst_valid  output  1  FIFO not empty
inst_pc  output  ADDR_WIDTH  PC of the FIFO head
inst_data  output  32  instruction at the FIFO head
inst_ready  input  1  decode pops the head when inst_valid && inst_ready

Behaviour:
- Reset (rst=0, takes effect immediately):
  - read_en=0, addr_read=0, pc=RESET_PC, FIFO empty, inst_valid=0, state=IDLE.
  - The cache shares this reset, so no response can arrive for a pre-reset request.
- Cache handshake:
  - read_en and addr_read are held constant until ready=1; exactly one request is outstanding at a time.
  - A request is never withdrawn before ready.
  - Fastest issue is back-to-back: the new address is presented the cycle after ready.
- Occupancy: count = FIFO entries; count_next = count + push - pop. An issue requires count_next < 2^FIFO_DEPTH_WIDTH. A push therefore never overflows.
- PC arithmetic: pc + 4 modulo 2^ADDR_WIDTH, so 0xFFFFFFFC wraps to 0.
- State IDLE (read_en=0):
  - redirect_en: pc <= redirect_pc, flush, stay IDLE.
  - else, if there is space: read_en <= 1, addr_read <= pc, go to REQ.
- State REQ (read_en=1):
  - ready and !redirect_en:
    - Push {addr_read, data_in}; pc <= addr_read + 4.
    - If space remains, addr_read <= addr_read + 4 and stay REQ.
    - Otherwise read_en <= 0 and go to IDLE.
  - ready and redirect_en: discard data_in, flush, pc <= redirect_pc, read_en <= 0, go to IDLE.
  - !ready and redirect_en: flush, pc <= redirect_pc, go to DROP with read_en and addr_read unchanged.
  - Otherwise hold.
- State DROP (response to be discarded; read_en held):
  - ready: discard, read_en <= 0, go to IDLE. A redirect_en in the same cycle also updates pc.
  - redirect_en without ready: pc <= redirect_pc, stay DROP.
- FIFO:
  - Circular with read/write pointers and a wrap bit, so full and empty are distinguishable.
  - Simultaneous push and pop are allowed, including when full or empty-then-push.
  - A pop while empty is ignored.
  - Head outputs are driven directly from storage; a push reaches inst_valid one cycle later.
- Redirect priority: flush overrides push and pop in the same cycle. inst_valid=0 in the following cycle.
- No stall input: backpressure is only via inst_ready and FIFO fullness.

Test Plan:
- Reset release, cache ready 1 cycle after each read_en, inst_ready=1:
  - addr_read sequence is 0xbfc00000, 0xbfc00004, 0xbfc00008…
  - inst_pc/inst_data match in order, one instruction per 2 cycles.
- inst_ready=0, immediate ready:
  - Exactly 8 entries are pushed, then read_en=0.
  - Raising inst_ready for 1 cycle pops one entry and re-issues at 0xbfc00020.
- redirect_en with redirect_pc=0x80001003 while in REQ, ready 3 cycles later:
  - The returned word is dropped and inst_valid stays 0.
  - The next request has addr_read=0x80001000.
- redirect_en in the same cycle as ready:
  - No push occurs and the FIFO is empty the next cycle.
  - The next issue is at redirect_pc.
- redirect to 0xFFFFFFF8, immediate ready: fetched addresses are 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- rst asserted mid-REQ with 3 entries buffered:
  - read_en=0 and inst_valid=0 immediately.
  - After release, the first request is at 0xbfc00000.
